ir_move_sequencer: RTL and testbench

IR_MOVE_SEQUENCER -- requirements
Module: ir_move_sequencer

---
 rtl/ir_move_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_ir_move_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_move_sequencer.sv
// ----------------------------------------------------------------------------
// ir_move_sequencer
//
// Purpose:
//    Queues up to four 12-bit move commands and plays them out one at a time.
//    For each command the IR transmitter is enabled for a fixed number of
//    cycles. The block then waits for a time proportional to the move size
//    (r + theta + 1 units) and pulses move_done. After that it returns to
//    IDLE, where the next queued command, if any, is picked up.
//
// Parameters:
//    IR_TRANSMIT_DELAY_COUNT : cycles transmit_ir stays high per command (>= 1)
//    MOVE_DELAY_FACTOR       : cycles per move unit (>= 1)
//
// Ports:
//    clock        in   rising-edge clock
//    reset        in   asynchronous active-high reset
//    cmd_data     in   [11:0] move command, r = [7:0], theta = [11:8]
//    cmd_valid    in   requester offers cmd_data
//    cmd_ready    out  queue has room (queue_count < 4)
//    flush        in   drop every queued command that has not started
//    move_command out  [11:0] command currently being executed
//    transmit_ir  out  IR transmitter enable
//    busy         out  high whenever the sequencer is not IDLE
//    move_done    out  one-cycle pulse at the end of each move
//    queue_count  out  [2:0] number of queued commands, 0..4
// ----------------------------------------------------------------------------
module ir_move_sequencer #(
   parameter int IR_TRANSMIT_DELAY_COUNT = 5000000,
   parameter int MOVE_DELAY_FACTOR       = 13500000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [11:0] cmd_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        flush,
   output logic [11:0] move_command,
   output logic        transmit_ir,
   output logic        busy,
   output logic        move_done,
   output logic [2:0]  queue_count
);

   localparam int TX_W = $clog2(IR_TRANSMIT_DELAY_COUNT + 1);
   localparam int IN_W = $clog2(MOVE_DELAY_FACTOR + 1);

   localparam logic [TX_W-1:0] TX_LAST      = TX_W'(IR_TRANSMIT_DELAY_COUNT - 1);
   localparam logic [TX_W-1:0] TX_ONE       = TX_W'(1);
   localparam logic [IN_W-1:0] INNER_RELOAD = IN_W'(MOVE_DELAY_FACTOR);
   localparam logic [IN_W-1:0] INNER_ONE    = IN_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      TRANSMIT,
      MOVE_WAIT,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic [11:0]     fifo_mem [4];
   logic [1:0]      wr_ptr;
   logic [1:0]      rd_ptr;
   logic [2:0]      count;
   logic            push;
   logic            pop;

   logic [TX_W-1:0] tx_count;
   logic [8:0]      unit_count;
   logic [IN_W-1:0] inner_count;
   logic [8:0]      unit_load;

   // The queue takes a command whenever it has room. A flush on the same
   // edge wins, so a command offered alongside a flush is dropped. A pop only
   // happens from IDLE, and never while a flush is discarding the queue.
   assign cmd_ready   = (count < 3'd4);
   assign queue_count = count;
   assign push        = cmd_valid && cmd_ready && !flush;
   assign pop         = (state == IDLE) && (count != 3'd0) && !flush;

   // Move size in units. It is computed 9 bits wide so that 255 + 15 + 1
   // fits without wrapping. A zero command therefore still takes one unit.
   assign unit_load = {1'b0, move_command[7:0]} + {5'b0_0000, move_command[11:8]} + 9'd1;

   // FIFO storage. This has no reset: the contents are only meaningful
   // between the pointers, and the pointers themselves are reset.
   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr] <= cmd_data;
      end
   end

   // FIFO bookkeeping. A flush collapses the queue by snapping the read
   // pointer onto the write pointer. A simultaneous push and pop leave the
   // count unchanged while both pointers advance, which keeps the order intact.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else if (flush) begin
         rd_ptr <= wr_ptr;
         count  <= 3'd0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         if (push && !pop) begin
            count <= count + 3'd1;
         end else if (pop && !push) begin
            count <= count - 3'd1;
         end
      end
   end

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. TRANSMIT ends after its last counted cycle. MOVE_WAIT
   // ends when both the inner cycle counter and the unit counter reach one,
   // which is the final cycle of the final unit.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (pop) begin
               next_state = TRANSMIT;
            end
         end
         TRANSMIT: begin
            if (tx_count == TX_LAST) begin
               next_state = MOVE_WAIT;
            end
         end
         MOVE_WAIT: begin
            if ((inner_count == INNER_ONE) && (unit_count == 9'd1)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Outputs decode directly from the state. Because of this, a reset drops
   // transmit_ir, busy and move_done immediately, without waiting for a clock.
   always_comb begin
      transmit_ir = (state == TRANSMIT);
      move_done   = (state == DONE);
      busy        = (state != IDLE);
   end

   // Datapath for the current command. The popped command is latched into
   // move_command and held until the next pop. The transmit counter times the
   // IR burst. The unit and inner counters together time the move, and the
   // inner counter is reloaded once per unit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         move_command <= 12'h000;
         tx_count     <= '0;
         unit_count   <= 9'd0;
         inner_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  move_command <= fifo_mem[rd_ptr];
                  tx_count     <= '0;
               end
            end
            TRANSMIT: begin
               if (tx_count == TX_LAST) begin
                  unit_count  <= unit_load;
                  inner_count <= INNER_RELOAD;
               end else begin
                  tx_count <= tx_count + TX_ONE;
               end
            end
            MOVE_WAIT: begin
               if (inner_count == INNER_ONE) begin
                  if (unit_count > 9'd1) begin
                     unit_count  <= unit_count - 9'd1;
                     inner_count <= INNER_RELOAD;
                  end
               end else begin
                  inner_count <= inner_count - INNER_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ir_move_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ir_move_sequencer
//
// Purpose:
//    Self-checking bench for ir_move_sequencer with short delays (3 transmit
//    cycles, 2 cycles per move unit). Each directed command carries a
//    hand-computed completion delay, measured from the rise of transmit_ir
//    to move_done. A monitor pops these expectations whenever the DUT
//    starts a command or finishes a move.
// ----------------------------------------------------------------------------
module tb_ir_move_sequencer;

   localparam int TX_CYC = 3;
   localparam int MDF    = 2;

   typedef struct {
      logic [11:0] cmd;
      int          delay;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] cmd_data = 12'h000;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        flush = 1'b0;
   logic [11:0] move_command;
   logic        transmit_ir;
   logic        busy;
   logic        move_done;
   logic [2:0]  queue_count;

   int   checks = 0;
   int   failures = 0;
   int   done_count = 0;
   int   cyc = 0;
   int   rise_cyc = 0;
   bit   in_flight = 1'b0;
   bit   prev_tx = 1'b0;
   exp_t cur;
   exp_t exp_q [$];

   ir_move_sequencer #(
      .IR_TRANSMIT_DELAY_COUNT(TX_CYC),
      .MOVE_DELAY_FACTOR(MDF)
   ) dut (
      .clock(clock),
      .reset(reset),
      .cmd_data(cmd_data),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .flush(flush),
      .move_command(move_command),
      .transmit_ir(transmit_ir),
      .busy(busy),
      .move_done(move_done),
      .queue_count(queue_count)
   );

   // 10 time-unit clock.
   always #5 clock = ~clock;

   // Hard stop in case something wedges the main sequence.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Offers one command on the next edge. Before the edge, it checks that
   // cmd_ready matches whether the command should be accepted. An accepted
   // command is added to the scoreboard.
   task automatic apply_stimulus(input logic [11:0] cmd, input int delay,
                                 input bit accept);
      exp_t e;
      @(negedge clock);
      #1;
      cmd_data  = cmd;
      cmd_valid = 1'b1;
      check_output("cmd_ready", cmd_ready, accept);
      if (accept) begin
         e.cmd   = cmd;
         e.delay = delay;
         exp_q.push_back(e);
      end
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_for_done(input int target, input int budget);
      int n = 0;
      while ((done_count < target) && (n < budget)) begin
         @(negedge clock);
         #1;
         n++;
      end
      check_output("done_count", done_count, target);
   endtask

   // Monitor. Samples on the falling edge. On each transmit_ir rise it
   // checks move_command against the scoreboard head. It also checks the
   // burst length, and times move_done against the expected delay.
   always @(negedge clock) begin
      cyc++;
      if (reset) begin
         in_flight = 1'b0;
         prev_tx   = 1'b0;
      end else begin
         if (transmit_ir && !prev_tx) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_tx", transmit_ir, 0);
            end else begin
               cur = exp_q.pop_front();
               check_output("move_command", move_command, cur.cmd);
               rise_cyc  = cyc;
               in_flight = 1'b1;
            end
         end
         if (!transmit_ir && prev_tx) begin
            check_output("tx_width", cyc - rise_cyc, TX_CYC);
         end
         if (move_done) begin
            if (!in_flight) begin
               check_output("spurious_done", move_done, 0);
            end else begin
               check_output("done_delay", cyc - rise_cyc, cur.delay);
               done_count++;
               in_flight = 1'b0;
            end
         end
         prev_tx = transmit_ir;
      end
   end

   // Directed sequence.
   initial begin
      int n;

      // Reset state.
      reset = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      check_output("rst_transmit_ir", transmit_ir, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_move_done", move_done, 0);
      check_output("rst_queue_count", queue_count, 0);
      check_output("rst_move_command", move_command, 12'h000);
      check_output("rst_cmd_ready", cmd_ready, 1);
      reset = 1'b0;

      // Single command r=2 theta=1: 4 units, so the delay is 3 + 4*2 = 11.
      $display("[TB] single command");
      apply_stimulus(12'h102, 11, 1'b1);
      @(negedge clock);
      #1;
      check_output("single_pre_tx", transmit_ir, 0);
      check_output("single_count1", queue_count, 1);
      @(negedge clock);
      #1;
      check_output("single_tx_high", transmit_ir, 1);
      check_output("single_busy", busy, 1);
      check_output("single_count0", queue_count, 0);
      wait_for_done(1, 100);
      @(negedge clock);
      #1;
      check_output("single_busy_low", busy, 0);
      check_output("single_done_low", move_done, 0);
      check_output("single_hold_cmd", move_command, 12'h102);

      // Zero command: 1 unit, so the delay is 3 + 2 = 5.
      $display("[TB] zero command");
      apply_stimulus(12'h000, 5, 1'b1);
      wait_for_done(2, 100);

      // Queue full: start one command, then offer five more while it runs.
      $display("[TB] queue full");
      apply_stimulus(12'h201, 11, 1'b1);
      repeat (2) @(negedge clock);
      #1;
      check_output("full_first_tx", transmit_ir, 1);
      apply_stimulus(12'h001, 7, 1'b1);
      apply_stimulus(12'h100, 7, 1'b1);
      apply_stimulus(12'h003, 11, 1'b1);
      apply_stimulus(12'h305, 21, 1'b1);
      @(negedge clock);
      #1;
      check_output("full_count4", queue_count, 4);
      apply_stimulus(12'h0FF, 0, 1'b0);
      @(negedge clock);
      #1;
      check_output("full_count_stays4", queue_count, 4);
      wait_for_done(7, 400);

      // Push on the same edge as an IDLE pop at count 1.
      $display("[TB] simultaneous push/pop");
      apply_stimulus(12'h004, 13, 1'b1);
      apply_stimulus(12'h002, 9, 1'b1);
      @(negedge clock);
      #1;
      check_output("pushpop_count1", queue_count, 1);
      wait_for_done(9, 200);

      // Flush during the first command's MOVE_WAIT.
      $display("[TB] flush");
      apply_stimulus(12'h101, 9, 1'b1);
      apply_stimulus(12'h002, 9, 1'b1);
      apply_stimulus(12'h003, 11, 1'b1);
      apply_stimulus(12'h004, 13, 1'b1);
      n = 0;
      while (transmit_ir && (n < 20)) begin
         @(negedge clock);
         #1;
         n++;
      end
      check_output("flush_tx_ended", transmit_ir, 0);
      flush = 1'b1;
      exp_q.delete();
      @(posedge clock);
      #1;
      flush = 1'b0;
      check_output("flush_count0", queue_count, 0);
      wait_for_done(10, 100);
      repeat (20) @(negedge clock);
      #1;
      check_output("flush_no_tx", transmit_ir, 0);
      check_output("flush_idle", busy, 0);
      check_output("flush_done_total", done_count, 10);

      // Reset in the middle of TRANSMIT, with a second command queued.
      $display("[TB] reset mid-transmit");
      apply_stimulus(12'h050, 165, 1'b1);
      apply_stimulus(12'h001, 7, 1'b1);
      @(negedge clock);
      #1;
      check_output("abort_tx_high", transmit_ir, 1);
      reset = 1'b1;
      #1;
      check_output("abort_tx_low", transmit_ir, 0);
      check_output("abort_count0", queue_count, 0);
      check_output("abort_busy", busy, 0);
      check_output("abort_cmd", move_command, 12'h000);
      exp_q.delete();
      repeat (3) @(negedge clock);
      #1;

      // The first edge after reset releases must accept a push.
      begin
         exp_t e;
         reset     = 1'b0;
         cmd_data  = 12'h000;
         cmd_valid = 1'b1;
         check_output("post_reset_ready", cmd_ready, 1);
         e.cmd   = 12'h000;
         e.delay = 5;
         exp_q.push_back(e);
         @(posedge clock);
         #1;
         cmd_valid = 1'b0;
      end
      @(negedge clock);
      #1;
      check_output("post_reset_count1", queue_count, 1);
      wait_for_done(11, 100);
      repeat (10) @(negedge clock);
      #1;
      check_output("final_done_total", done_count, 11);
      check_output("final_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
